// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-store loader.
// Default widths match the core's program counter and machine word.
package loader_pkg;

    localparam int D_DEF    = 12;
    localparam int W_DEF    = 9;
    localparam int MAX_ADDR = 2**D_DEF - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } ldr_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Host word stream into the loader.
// A word transfers on a posedge where in_valid and in_ready are both high; in_data and
// in_last are only meaningful while in_valid is high, and the host holds them until accepted.
interface prog_loader_if #(
    parameter int W = 9
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/ldr_addr_ctr.sv
// Write-address and word-count register for the loader.
// The address saturates at its top value; the count is one bit wider so a full store reads 2**D.
module ldr_addr_ctr #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [D-1:0] addr,
    output logic [D:0]   count,
    output logic         tc
);

    assign tc = (addr == {D{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr  <= '0;
            count <= '0;
        end else if (clr) begin
            addr  <= '0;
            count <= '0;
        end else if (inc) begin
            if (!tc) begin
                addr <= addr + D'(1);
            end
            count <= count + (D+1)'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams host words into instruction memory from address 0, holding the core in reset
// until the final word has been written, then tracks the core's done flag.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    prog_loader_if.slave  host,
    output logic          wr_en,
    output logic [D-1:0]  wr_addr,
    output logic [W-1:0]  wr_data,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          prog_done,
    output logic [D:0]    loaded_count,
    output logic          err_overflow,
    output ldr_state_t    state_dbg
);

    ldr_state_t   state;
    ldr_state_t   state_next;
    logic         accept;
    logic         ctr_clr;
    logic         ctr_inc;
    logic         ctr_tc;
    logic         err_next;
    logic [D-1:0] addr;

    ldr_addr_ctr #(.D(D)) u_addr_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .inc   (ctr_inc),
        .addr  (addr),
        .count (loaded_count),
        .tc    (ctr_tc)
    );

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        err_next   = err_overflow;
        // in_ready is only ever high in LOAD, so this is the complete accept condition
        accept     = host.in_valid & host.in_ready;

        case (state)
            IDLE, DONE: begin
                if (load_req) begin
                    state_next = LOAD;
                    ctr_clr    = 1'b1;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    ctr_inc = 1'b1;
                    if (host.in_last) begin
                        state_next = RELEASE;
                    end else if (ctr_tc) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            RELEASE: state_next = RUN;
            RUN: begin
                if (core_done) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            host.in_ready <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            core_reset    <= 1'b1;
            busy          <= 1'b0;
            prog_done     <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state         <= state_next;
            host.in_ready <= (state_next == LOAD);
            core_reset    <= !((state_next == RUN) || (state_next == DONE));
            busy          <= (state_next == LOAD) || (state_next == RELEASE);
            prog_done     <= (state_next == DONE);
            err_overflow  <= err_next;
            wr_en         <= accept;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= host.in_data;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised load/run/overflow/reset scenarios for prog_loader with a write scoreboard.
// Small address width so the full-store and overflow boundaries are reachable quickly.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int TD   = 3;
    localparam int TW   = 9;
    localparam int NMAX = 2**TD;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            load_req = 1'b0;
    logic            core_done = 1'b0;
    logic            wr_en;
    logic [TD-1:0]   wr_addr;
    logic [TW-1:0]   wr_data;
    logic            core_reset;
    logic            busy;
    logic            prog_done;
    logic [TD:0]     loaded_count;
    logic            err_overflow;
    ldr_state_t      state_dbg;

    prog_loader_if #(.W(TW)) bus ();

    prog_loader #(.D(TD), .W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .host         (bus.slave),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_reset   (core_reset),
        .core_done    (core_done),
        .busy         (busy),
        .prog_done    (prog_done),
        .loaded_count (loaded_count),
        .err_overflow (err_overflow),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [TW+TD-1:0]   exp_q[$];
    logic [TW+TD-1:0]   exp_e;
    logic               acc_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every accepted word must appear as exactly one write on the following cycle.
    always @(negedge clk) begin
        check("wr_en_latency", wr_en, acc_d);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr %0d data %0h, required no write", wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", wr_addr, exp_e[TW+TD-1:TW]);
                check("wr_data", wr_data, exp_e[TW-1:0]);
            end
        end
        acc_d = bus.in_valid & bus.in_ready & reset;
    end

    // ---------------- driver tasks ----------------
    logic [TW-1:0] w_data[NMAX+1];
    int            w_gap[NMAX+1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            w_data[i] = TW'($urandom_range(0, 2**TW - 1));
            w_gap[i]  = $urandom_range(0, gap_max);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_prog_done"}, prog_done, 0);
        check({tag, "_loaded_count"}, loaded_count, 0);
        check({tag, "_err_overflow"}, err_overflow, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("load_in_ready", bus.in_ready, 1);
        check("load_core_reset", core_reset, 1);
        check("load_busy", busy, 1);
        check("load_prog_done", prog_done, 0);
        check("load_count_clear", loaded_count, 0);
        check("load_err_clear", err_overflow, 0);
    endtask

    task automatic send_word(input logic [TW-1:0] d, input bit last, input int gap,
                             input int idx, output bit ok);
        logic [TD-1:0] a;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (bus.in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        a = TD'(idx);
        if (ok) exp_q.push_back({a, d});
    endtask

    // Full load of n words from w_data/w_gap, ending in the first RUN cycle.
    task automatic do_load(input int n);
        bit ok;
        start_load();
        for (int i = 0; i < n; i++) begin
            send_word(w_data[i], (i == n - 1), w_gap[i], i, ok);
            check("word_accepted", ok, 1);
        end
        check("release_state", state_dbg, RELEASE);
        check("release_in_ready", bus.in_ready, 0);
        check("release_core_reset", core_reset, 1);
        check("release_busy", busy, 1);
        check("release_count", loaded_count, n);
        check("release_err", err_overflow, 0);
        tick();
        check("run_core_reset", core_reset, 0);
        check("run_busy", busy, 0);
        check("run_prog_done", prog_done, 0);
        check("run_state", state_dbg, RUN);
    endtask

    task automatic finish_run();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_prog_done", prog_done, 1);
        check("done_core_reset", core_reset, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // reset, then idle without load_req
        reset = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_core_reset", core_reset, 1);
            check("idle_in_ready", bus.in_ready, 0);
            check("idle_wr_en", wr_en, 0);
            check("idle_count", loaded_count, 0);
        end

        // basic 3-word load with continuous valid
        w_data[0] = 9'h1A5; w_data[1] = 9'h0F0; w_data[2] = 9'h100;
        w_gap[0] = 0; w_gap[1] = 0; w_gap[2] = 0;
        do_load(3);

        // run for 20 cycles with an ignored load_req, then done
        for (int c = 1; c < 20; c++) begin
            load_req = (c == 5);
            tick();
            check("run_hold_core_reset", core_reset, 0);
            check("run_hold_busy", busy, 0);
            check("run_hold_prog_done", prog_done, 0);
        end
        load_req = 1'b0;
        finish_run();
        tick();
        check("done_hold", prog_done, 1);

        // gaps: valid pattern 1,0,0,1,1
        fill(3, 0);
        w_gap[1] = 2;
        do_load(3);
        tick();
        check("gap_writes_drained", exp_q.size(), 0);
        finish_run();

        // random loads, including a full store ending exactly at the top address
        for (int k = 0; k < 6; k++) begin
            n = (k == 2) ? NMAX : $urandom_range(1, NMAX);
            fill(n, 2);
            do_load(n);
            finish_run();
        end

        // overflow: NMAX+1 words without in_last
        fill(NMAX + 1, 1);
        start_load();
        for (int i = 0; i < NMAX; i++) begin
            send_word(w_data[i], 1'b0, w_gap[i], i, ok);
            check("ovf_word_accepted", ok, 1);
        end
        check("ovf_err", err_overflow, 1);
        check("ovf_state", state_dbg, IDLE);
        check("ovf_in_ready", bus.in_ready, 0);
        check("ovf_core_reset", core_reset, 1);
        check("ovf_busy", busy, 0);
        check("ovf_count", loaded_count, NMAX);
        send_word(w_data[NMAX], 1'b0, 0, NMAX, ok);
        check("ovf_extra_rejected", ok, 0);
        check("ovf_err_sticky", err_overflow, 1);

        // load from IDLE clears the error
        fill(2, 1);
        do_load(2);
        finish_run();

        // reset after 2 of 5 words
        fill(5, 1);
        start_load();
        for (int i = 0; i < 2; i++) begin
            send_word(w_data[i], 1'b0, w_gap[i], i, ok);
            check("mid_word_accepted", ok, 1);
        end
        reset = 1'b0;
        tick();
        check_reset_vals("midreset");
        reset = 1'b1;
        tick();
        fill(3, 1);
        do_load(3);
        finish_run();

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
